mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
- Moore-style control FSM that sequences the multicycle MIPS datapath: PC, NPC, MAR, MDR, IR, register file, ALU, RAM and the mux selects.
- Drives a RAM handshake: mem_en request, then wait for mem_moc (memory-operation-complete), with a bounded wait.
- Decodes the IR opcode/funct and keeps a retired-instruction counter.
- Flags illegal opcodes and memory time-outs.

Parameters:
- MEM_TIMEOUT, 16: maximum cycles spent waiting for mem_moc in any memory state before a bus error.
- COUNT_W, 32: width of instr_count.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- alu_zero  in  1  ALU zero flag.
- mem_moc  in  1  RAM operation complete.
- pc_ld  out  1  load PC.
- npc_ld  out  1  load NPC.
- mar_ld  out  1  load MAR.
- mdr_ld  out  1  load MDR.
- ir_ld  out  1  load IR.
- rf_we  out  1  register-file write.
- mem_en  out  1  RAM request.
- mem_rw  out  1  RAM direction: 1=read, 0=write.
- alu_op  out  4  ALU operation: ADD=0, SUB=1, AND=2, OR=3, SLT=4.
- alu_src_a  out  1  ALU A select: 0=PC, 1=reg A.
- alu_src_b  out  2  ALU B select: 0=reg B, 1=const 4, 2=sign-ext imm.
- reg_dst  out  1  write-register select: 0=rt, 1=rd.
- mem_to_reg  out  1  write-data select: 1=MDR, 0=ALU.
- pc_src  out  2  PC source: 0=ALU, 1=branch adder, 2=jump target.
- state  out  4  current FSM state.
- instr_count  out  COUNT_W  retired instructions.
- illegal_op  out  1  sticky: unsupported opcode/funct seen.
- bus_err  out  1  sticky: memory time-out.

Behaviour:
- State encoding: FETCH0=0, FETCH1=1, FETCH2=2, DECODE=3, EXEC_R=4, EXEC_I=5, MEM_ADDR=6, MEM_RD=7, MEM_WR=8, WB_ALU=9, WB_LOAD=10, BRANCH=11, JUMP=12, ERR=13. Codes 14-15 go to FETCH0.
- Reset (reset=0, asynchronous): state=FETCH0, instr_count=0, illegal_op=0, bus_err=0, wait counter=0. All other outputs take the FETCH0 decode.
- Outputs are decoded from state only. The single exception is pc_ld in BRANCH.
- Every state not listed below drives 0 on all control outputs.
- FETCH0: mar_ld=1, npc_ld=1. Next state FETCH1.
- FETCH1: mem_en=1, mem_rw=1, mdr_ld=1. Stays until mem_moc=1, then FETCH2.
- FETCH2: ir_ld=1, pc_ld=1, pc_src=0, alu_src_a=0, alu_src_b=1, alu_op=ADD. Next state DECODE.
- DECODE dispatch:
  - opcode 000000 with funct 100000/100010/100100/100101/101010 -> EXEC_R.
  - 001000 (ADDI) -> EXEC_I.
  - 100011 (LW) and 101011 (SW) -> MEM_ADDR.
  - 000100 (BEQ) and 000101 (BNE) -> BRANCH.
  - 000010 (J) -> JUMP.
  - Anything else sets illegal_op and goes to FETCH0; it does not count as retired.
- EXEC_R: alu_src_a=1, alu_src_b=0. alu_op from funct: ADD, SUB, AND, OR, SLT. Next state WB_ALU.
- EXEC_I: alu_src_a=1, alu_src_b=2, ADD. Next state WB_ALU.
- WB_ALU: rf_we=1, mem_to_reg=0. reg_dst=1 for R-type, 0 for ADDI. Holds the EXEC ALU controls. Retires, then FETCH0.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, ADD, mar_ld=1. Next state MEM_RD for LW, MEM_WR for SW.
- MEM_RD: mem_en=1, mem_rw=1, mdr_ld=1. Waits for mem_moc, then WB_LOAD.
- MEM_WR: mem_en=1, mem_rw=0. Waits for mem_moc, then retires and goes to FETCH0.
- WB_LOAD: rf_we=1, mem_to_reg=1, reg_dst=0. Retires, then FETCH0.
- BRANCH: alu_src_a=1, alu_src_b=0, SUB, pc_src=1. pc_ld=(BEQ&alu_zero)|(BNE&~alu_zero). Retires, then FETCH0.
- JUMP: pc_ld=1, pc_src=2. Retires, then FETCH0.
- Retire: instr_count increments by 1 on the transition to FETCH0 from a retiring state; it wraps modulo 2^COUNT_W.
- Latency with immediate mem_moc: R/ADDI 6 cycles, LW 7, SW 6, BEQ/BNE 5, J 5.
- Memory wait counter:
  - Clears on entry to FETCH1, MEM_RD and MEM_WR.
  - Increments each cycle mem_moc=0.
  - Reaching MEM_TIMEOUT-1 with mem_moc=0 sets bus_err and goes to ERR.
  - mem_moc=1 in that same cycle wins: normal transition, no error.
- ERR: all control outputs 0. Stays until reset.
- mem_moc outside a wait state is ignored.
- Reset asserted mid-wait returns to FETCH0 immediately; no retire.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state codes;
  - opcode constants OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J;
  - funct constants;
  - alu_op, alu_src_b and pc_src encodings.
- One sub-module, mips_alu_decode: combinational funct -> alu_op plus funct-legal flag.

Test Plan:
- R-type ADD (opcode 0, funct 0x20), mem_moc=1 in FETCH1 -> states 0,1,2,3,4,9,0; rf_we=1 for exactly one cycle with reg_dst=1; instr_count 0->1.
- LW (0x23) with mem_moc delayed 3 cycles in FETCH1 and 2 in MEM_RD -> 12 cycles total; mem_to_reg=1 in WB_LOAD; mem_rw=1 throughout.
- BEQ with alu_zero=1 -> pc_ld=1 and pc_src=1 in BRANCH. BNE with alu_zero=1 -> pc_ld=0 in BRANCH.
- Opcode 0x3F -> illegal_op=1 after DECODE, back to FETCH0, instr_count unchanged.
- SW with mem_moc held 0 and MEM_TIMEOUT=16 -> ERR after 16 MEM_WR cycles; bus_err=1; stays in ERR. Repeat with mem_moc=1 on cycle 16 -> FETCH0, no error.
- Drive reset low mid-MEM_RD -> state=0 and all flags/count 0 with no clock edge; normal fetch resumes after release.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// funct codes and datapath select values.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH0  = 4'd0,
        S_FETCH1  = 4'd1,
        S_FETCH2  = 4'd2,
        S_DECODE  = 4'd3,
        S_EXEC_R  = 4'd4,
        S_EXEC_I  = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD  = 4'd7,
        S_MEM_WR  = 4'd8,
        S_WB_ALU  = 4'd9,
        S_WB_LOAD = 4'd10,
        S_BRANCH  = 4'd11,
        S_JUMP    = 4'd12,
        S_ERR     = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4;

    localparam logic [1:0] SRCB_REGB = 2'd0;
    localparam logic [1:0] SRCB_FOUR = 2'd1;
    localparam logic [1:0] SRCB_IMM  = 2'd2;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_BRANCH = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

endpackage

// File: rtl/mips_alu_decode.sv
// R-type funct decode: ALU operation plus a flag saying the funct is supported.
module mips_alu_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic       funct_ok
);

    always_comb begin
        alu_op   = ALU_ADD;
        funct_ok = 1'b1;
        case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_SLT:  alu_op = ALU_SLT;
            default: funct_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore control FSM for the multicycle MIPS datapath, with a bounded RAM
// handshake, retired-instruction counter and sticky error flags.
//
// state    | meaning
// FETCH0   | MAR <- PC, NPC load
// FETCH1   | instruction read, wait for mem_moc
// FETCH2   | IR load, PC <- PC + 4
// DECODE   | opcode dispatch / illegal detect
// EXEC_R   | R-type ALU op
// EXEC_I   | ADDI ALU op
// MEM_ADDR | effective address into MAR
// MEM_RD   | data read, wait for mem_moc
// MEM_WR   | data write, wait for mem_moc
// WB_ALU   | write ALU result
// WB_LOAD  | write MDR
// BRANCH   | compare and conditional PC load
// JUMP     | PC <- jump target
// ERR      | memory time-out, parked until reset
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int COUNT_W     = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               alu_zero,
    input  logic               mem_moc,
    output logic               pc_ld,
    output logic               npc_ld,
    output logic               mar_ld,
    output logic               mdr_ld,
    output logic               ir_ld,
    output logic               rf_we,
    output logic               mem_en,
    output logic               mem_rw,
    output logic [3:0]         alu_op,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic [1:0]         pc_src,
    output logic [3:0]         state,
    output logic [COUNT_W-1:0] instr_count,
    output logic               illegal_op,
    output logic               bus_err
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt;
    logic              in_wait, wait_expired, is_rtype;
    logic              retire, set_ill, set_berr;
    logic [3:0]        r_alu_op;
    logic              funct_ok;

    mips_alu_decode u_alu_decode (
        .funct    (funct),
        .alu_op   (r_alu_op),
        .funct_ok (funct_ok)
    );

    assign state        = state_q;
    assign is_rtype     = (opcode == OP_RTYPE);
    assign in_wait      = (state_q == S_FETCH1) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    // mem_moc in the final allowed cycle still completes normally
    assign wait_expired = !mem_moc && (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

    always_comb begin
        state_d    = S_FETCH0;
        retire     = 1'b0;
        set_ill    = 1'b0;
        set_berr   = 1'b0;
        pc_ld      = 1'b0;
        npc_ld     = 1'b0;
        mar_ld     = 1'b0;
        mdr_ld     = 1'b0;
        ir_ld      = 1'b0;
        rf_we      = 1'b0;
        mem_en     = 1'b0;
        mem_rw     = 1'b0;
        alu_op     = ALU_ADD;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REGB;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        pc_src     = PCSRC_ALU;
        case (state_q)
            S_FETCH0: begin
                mar_ld  = 1'b1;
                npc_ld  = 1'b1;
                state_d = S_FETCH1;
            end
            S_FETCH1: begin
                mem_en = 1'b1;
                mem_rw = 1'b1;
                mdr_ld = 1'b1;
                if (mem_moc)           state_d = S_FETCH2;
                else if (wait_expired) begin state_d = S_ERR; set_berr = 1'b1; end
                else                   state_d = S_FETCH1;
            end
            S_FETCH2: begin
                ir_ld     = 1'b1;
                pc_ld     = 1'b1;
                alu_src_b = SRCB_FOUR;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     if (funct_ok) state_d = S_EXEC_R; else set_ill = 1'b1;
                    OP_ADDI:      state_d = S_EXEC_I;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    default:      set_ill = 1'b1;
                endcase
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = r_alu_op;
                state_d   = S_WB_ALU;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = S_WB_ALU;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                mar_ld    = 1'b1;
                state_d   = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_en = 1'b1;
                mem_rw = 1'b1;
                mdr_ld = 1'b1;
                if (mem_moc)           state_d = S_WB_LOAD;
                else if (wait_expired) begin state_d = S_ERR; set_berr = 1'b1; end
                else                   state_d = S_MEM_RD;
            end
            S_MEM_WR: begin
                mem_en = 1'b1;
                if (mem_moc)           retire = 1'b1;
                else if (wait_expired) begin state_d = S_ERR; set_berr = 1'b1; end
                else                   state_d = S_MEM_WR;
            end
            S_WB_ALU: begin
                rf_we     = 1'b1;
                reg_dst   = is_rtype;
                alu_src_a = 1'b1;
                alu_src_b = is_rtype ? SRCB_REGB : SRCB_IMM;
                alu_op    = is_rtype ? r_alu_op : ALU_ADD;
                retire    = 1'b1;
            end
            S_WB_LOAD: begin
                rf_we      = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = PCSRC_BRANCH;
                pc_ld     = ((opcode == OP_BEQ) && alu_zero) || ((opcode == OP_BNE) && !alu_zero);
                retire    = 1'b1;
            end
            S_JUMP: begin
                pc_ld  = 1'b1;
                pc_src = PCSRC_JUMP;
                retire = 1'b1;
            end
            S_ERR:   state_d = S_ERR;
            default: state_d = S_FETCH0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_FETCH0;
            wait_cnt    <= '0;
            instr_count <= '0;
            illegal_op  <= 1'b0;
            bus_err     <= 1'b0;
        end else begin
            state_q <= state_d;
            // wait states are never entered back-to-back, so clearing outside them clears on entry
            if (in_wait) begin
                if (!mem_moc) wait_cnt <= wait_cnt + WAIT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
            if (retire)   instr_count <= instr_count + COUNT_W'(1);
            if (set_ill)  illegal_op  <= 1'b1;
            if (set_berr) bus_err     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: the stimulus queues per-cycle
// expectations, a negedge monitor pops and compares them.
module tb_mips_multicycle_ctrl;

    typedef struct packed {
        logic       pc_ld, npc_ld, mar_ld, mdr_ld, ir_ld, rf_we, mem_en, mem_rw;
        logic [3:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_dst, mem_to_reg;
        logic [1:0] pc_src;
    } ctl_t;

    typedef struct {
        logic [3:0]  st;
        ctl_t        ctl;
        logic [31:0] cnt;
        logic        ill;
        logic        berr;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode, funct;
    logic        alu_zero, mem_moc;
    logic        pc_ld, npc_ld, mar_ld, mdr_ld, ir_ld, rf_we, mem_en, mem_rw;
    logic [3:0]  alu_op;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic        reg_dst, mem_to_reg;
    logic [1:0]  pc_src;
    logic [3:0]  state;
    logic [31:0] instr_count;
    logic        illegal_op, bus_err;

    exp_t        sb_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] ecnt;
    logic        eill, eberr;
    ctl_t        act_ctl;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.MEM_TIMEOUT(16), .COUNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .alu_zero(alu_zero), .mem_moc(mem_moc),
        .pc_ld(pc_ld), .npc_ld(npc_ld), .mar_ld(mar_ld), .mdr_ld(mdr_ld),
        .ir_ld(ir_ld), .rf_we(rf_we), .mem_en(mem_en), .mem_rw(mem_rw),
        .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .pc_src(pc_src),
        .state(state), .instr_count(instr_count),
        .illegal_op(illegal_op), .bus_err(bus_err)
    );

    assign act_ctl = {pc_ld, npc_ld, mar_ld, mdr_ld, ir_ld, rf_we, mem_en, mem_rw,
                      alu_op, alu_src_a, alu_src_b, reg_dst, mem_to_reg, pc_src};

    function automatic logic [3:0] fn_alu(input logic [5:0] fn);
        case (fn)
            6'h22:   return 4'd1;
            6'h24:   return 4'd2;
            6'h25:   return 4'd3;
            6'h2A:   return 4'd4;
            default: return 4'd0;
        endcase
    endfunction

    // Expected control word per state, written from the state-by-state output list.
    function automatic ctl_t model(input logic [3:0] st, input logic [5:0] op,
                                   input logic [5:0] fn, input logic z);
        ctl_t c;
        c = '0;
        case (st)
            4'd0:  begin c.mar_ld = 1; c.npc_ld = 1; end
            4'd1:  begin c.mem_en = 1; c.mem_rw = 1; c.mdr_ld = 1; end
            4'd2:  begin c.ir_ld = 1; c.pc_ld = 1; c.alu_src_b = 2'd1; end
            4'd4:  begin c.alu_src_a = 1; c.alu_op = fn_alu(fn); end
            4'd5:  begin c.alu_src_a = 1; c.alu_src_b = 2'd2; end
            4'd6:  begin c.alu_src_a = 1; c.alu_src_b = 2'd2; c.mar_ld = 1; end
            4'd7:  begin c.mem_en = 1; c.mem_rw = 1; c.mdr_ld = 1; end
            4'd8:  begin c.mem_en = 1; end
            4'd9:  begin
                c.rf_we = 1; c.alu_src_a = 1;
                c.reg_dst   = (op == 6'h00);
                c.alu_src_b = (op == 6'h00) ? 2'd0 : 2'd2;
                c.alu_op    = (op == 6'h00) ? fn_alu(fn) : 4'd0;
            end
            4'd10: begin c.rf_we = 1; c.mem_to_reg = 1; end
            4'd11: begin
                c.alu_src_a = 1; c.alu_op = 4'd1; c.pc_src = 2'd1;
                c.pc_ld = ((op == 6'h04) && z) || ((op == 6'h05) && !z);
            end
            4'd12: begin c.pc_ld = 1; c.pc_src = 2'd2; end
            default: c = '0;
        endcase
        return c;
    endfunction

    task automatic check(input string name, input string tag,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s [%s] t=%0t actual=%0h required=%0h", name, tag, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("state",       e.tag, 32'(state),       32'(e.st));
            check("ctl",         e.tag, 32'(act_ctl),     32'(e.ctl));
            check("instr_count", e.tag, instr_count,      e.cnt);
            check("illegal_op",  e.tag, 32'(illegal_op), 32'(e.ill));
            check("bus_err",     e.tag, 32'(bus_err),     32'(e.berr));
        end
    end

    task automatic step(input string tag, input logic [3:0] est, input logic moc);
        exp_t e;
        mem_moc = moc;
        e.st   = est;
        e.ctl  = model(est, opcode, funct, alu_zero);
        e.cnt  = ecnt;
        e.ill  = eill;
        e.berr = eberr;
        e.tag  = tag;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string tag, input int dly);
        step(tag, 4'd0, 1'b0);
        repeat (dly) step(tag, 4'd1, 1'b0);
        step(tag, 4'd1, 1'b1);
        step(tag, 4'd2, 1'b0);
        step(tag, 4'd3, 1'b0);
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
        opcode   = op;
        funct    = fn;
        alu_zero = z;
    endtask

    // Asynchronous reset asserted at posedge+1: the first check lands before any clock edge.
    task automatic do_reset(input string tag);
        reset = 1'b0;
        ecnt  = 0;
        eill  = 1'b0;
        eberr = 1'b0;
        step(tag, 4'd0, 1'b0);
        step(tag, 4'd0, 1'b0);
        reset = 1'b1;
    endtask

    logic [5:0] rfn [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    logic [5:0] bop [4] = '{6'h04, 6'h04, 6'h05, 6'h05};
    logic       bz  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        reset = 1'b0;
        set_instr(6'h00, 6'h20, 1'b0);
        mem_moc = 1'b0;
        ecnt = 0; eill = 1'b0; eberr = 1'b0;
        @(posedge clk);
        #1;
        step("reset", 4'd0, 1'b0);
        reset = 1'b1;

        for (int i = 0; i < 5; i++) begin
            set_instr(6'h00, rfn[i], 1'b0);
            fetch("rtype", 0);
            step("rtype", 4'd4, 1'b0);
            step("rtype", 4'd9, 1'b0);
            ecnt++;
        end

        set_instr(6'h08, 6'h3F, 1'b0);
        fetch("addi", 0);
        step("addi", 4'd5, 1'b0);
        step("addi", 4'd9, 1'b0);
        ecnt++;

        set_instr(6'h23, 6'h00, 1'b0);
        fetch("lw", 3);
        step("lw", 4'd6, 1'b0);
        step("lw", 4'd7, 1'b0);
        step("lw", 4'd7, 1'b0);
        step("lw", 4'd7, 1'b1);
        step("lw", 4'd10, 1'b0);
        ecnt++;

        set_instr(6'h2B, 6'h00, 1'b0);
        fetch("sw", 0);
        step("sw", 4'd6, 1'b0);
        step("sw", 4'd8, 1'b1);
        ecnt++;

        for (int i = 0; i < 4; i++) begin
            set_instr(bop[i], 6'h00, bz[i]);
            fetch("branch", 0);
            step("branch", 4'd11, 1'b0);
            ecnt++;
        end

        set_instr(6'h02, 6'h00, 1'b0);
        fetch("jump", 0);
        step("jump", 4'd12, 1'b0);
        ecnt++;

        set_instr(6'h3F, 6'h00, 1'b0);
        fetch("illegal_op", 0);
        eill = 1'b1;

        set_instr(6'h00, 6'h21, 1'b0);
        fetch("illegal_funct", 0);

        set_instr(6'h2B, 6'h00, 1'b0);
        fetch("sw_timeout", 0);
        step("sw_timeout", 4'd6, 1'b0);
        repeat (16) step("sw_timeout", 4'd8, 1'b0);
        eberr = 1'b1;
        repeat (3) step("err_hold", 4'd13, 1'b1);

        do_reset("reset_from_err");

        set_instr(6'h2B, 6'h00, 1'b0);
        fetch("sw_last_cycle", 0);
        step("sw_last_cycle", 4'd6, 1'b0);
        repeat (15) step("sw_last_cycle", 4'd8, 1'b0);
        step("sw_last_cycle", 4'd8, 1'b1);
        ecnt++;

        set_instr(6'h3F, 6'h00, 1'b0);
        fetch("illegal_again", 0);
        eill = 1'b1;

        set_instr(6'h23, 6'h00, 1'b0);
        fetch("lw_reset", 0);
        step("lw_reset", 4'd6, 1'b0);
        step("lw_reset", 4'd7, 1'b0);
        step("lw_reset", 4'd7, 1'b0);
        do_reset("reset_mid_rd");

        set_instr(6'h00, 6'h20, 1'b0);
        fetch("resume", 0);
        step("resume", 4'd4, 1'b0);
        step("resume", 4'd9, 1'b0);
        ecnt++;
        step("resume", 4'd0, 1'b0);

        @(negedge clk);
        #1;
        check("scoreboard_drain", "end", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
